// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions.
// Reset PC default, PC step, FSM states.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_inst.sv
// Shift-register instruction FIFO; entry 0 is the registered head.
// Push, pop, synchronous flush and occupancy count.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [63:0]   i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [CW-1:0] o_count,
    output logic [63:0]   o_head,
    output logic          o_valid
);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_wr_idx;
    logic [63:0]   w_ent [DEPTH];

    // A pop shifts everything down, so the write slot moves with it.
    assign w_wr_idx = r_count - CW'(i_pop);

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [63:0] r_ent;
        logic [63:0] w_up;

        if (g == DEPTH - 1) begin : g_last
            assign w_up = r_ent;
        end else begin : g_mid
            assign w_up = w_ent[g+1];
        end

        assign w_ent[g] = r_ent;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_ent <= '0;
            end else if (i_push && (w_wr_idx == CW'(g))) begin
                r_ent <= i_data;
            end else if (i_pop) begin
                r_ent <= w_up;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = w_ent[0];
    assign o_valid = (r_count != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IMEM request/response tracking,
// redirect/drain handling and the decoder-facing instruction FIFO.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    output logic        INST_VALID,
    input  logic        INST_READY
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0]   r_fpc;
    logic [31:0]   r_rpc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_discard_nxt;
    logic [CW-1:0] w_outst_nxt;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_sum;
    logic [31:0]   w_target;
    logic [63:0]   w_head;
    logic          w_credit;
    logic          w_grant;
    logic          w_redirect;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_valid;

    assign w_target   = word_align(BR_TARGET);
    assign w_sum      = {1'b0, r_outst} + {1'b0, w_count};
    assign w_credit   = (w_sum < (CW+1)'(DEPTH));
    assign IMEM_REQ   = (r_state == S_RUN) && w_credit;
    assign IMEM_ADDR  = r_fpc;
    assign w_grant    = IMEM_REQ && IMEM_GNT;
    assign w_redirect = BR_TAKEN && (r_state != S_BOOT);
    assign w_push     = IMEM_RVALID && (r_state == S_RUN) && !BR_TAKEN;
    assign w_pop      = w_fifo_valid && INST_READY;

    // Requests still owed a response after this cycle; on a redirect
    // every one of them must be thrown away.
    assign w_outst_nxt = r_outst + CW'(w_grant) - CW'(IMEM_RVALID);

    always_comb begin
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        unique case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN, S_DRAIN: begin
                if (BR_TAKEN) begin
                    w_discard_nxt = w_outst_nxt;
                    w_state_nxt   = (w_outst_nxt != '0) ? S_DRAIN : S_RUN;
                end else if ((r_state == S_DRAIN) && IMEM_RVALID
                             && (r_discard != '0)) begin
                    w_discard_nxt = r_discard - CW'(1);
                    if (r_discard == CW'(1)) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_BOOT;
            r_discard <= '0;
            r_outst   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
            r_outst   <= w_outst_nxt;
        end
    end

    // r_rpc is the PC owed to the next response that will be kept.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fpc <= RESET_PC;
            r_rpc <= RESET_PC;
        end else begin
            if (w_redirect) begin
                r_fpc <= w_target;
            end else if (w_grant) begin
                r_fpc <= r_fpc + PC_STEP;
            end
            if (w_redirect) begin
                r_rpc <= w_target;
            end else if (w_push) begin
                r_rpc <= r_rpc + PC_STEP;
            end
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push),
        .i_data  ({r_rpc, IMEM_RDATA}),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_count (w_count),
        .o_head  (w_head),
        .o_valid (w_fifo_valid)
    );

    assign INST_PC    = w_head[63:32];
    assign INST       = w_head[31:0];
    assign INST_VALID = w_fifo_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model
// and a PC scoreboard on the decoder side.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_VALID;
    logic        INST_READY;

    logic        gnt_en;
    logic        resp_en;
    logic        mem_rv;
    logic [31:0] mem_rdata;
    logic [31:0] next_addr;
    logic [31:0] mq [$];
    logic [31:0] g_log [$];
    logic [31:0] exp_q [$];
    int          n_grant;
    int          n_deliv;
    int          n_chk;
    int          n_pass;
    int          n_fail;
    logic        found;

    always #5 CLK = ~CLK;

    assign IMEM_GNT    = gnt_en;
    assign IMEM_RVALID = mem_rv;
    assign IMEM_RDATA  = mem_rdata;

    fetch_unit dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .INST        (INST),
        .INST_PC     (INST_PC),
        .INST_VALID  (INST_VALID),
        .INST_READY  (INST_READY)
    );

    // Memory returns the word address as data, in order, one cycle
    // after the grant at the earliest.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_rv    <= 1'b0;
            mem_rdata <= '0;
            mq.delete();
        end else begin
            if (IMEM_REQ && IMEM_GNT) begin
                mq.push_back(IMEM_ADDR);
                g_log.push_back(IMEM_ADDR);
                next_addr <= IMEM_ADDR + 32'd4;
                n_grant   <= n_grant + 1;
            end
            if (resp_en && mq.size() > 0) begin
                mem_rv    <= 1'b1;
                mem_rdata <= mq.pop_front();
            end else begin
                mem_rv    <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N && INST_VALID && INST_READY) begin
            logic [31:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("sb_pc", INST_PC, e);
            chk("sb_inst", INST, e);
            n_deliv++;
        end
    end

    task automatic fill_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(start + 32'(i * 4));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_deliv(input string tag, input int n);
        int tgt;
        int i;
        @(posedge CLK);
        tgt = n_deliv + n;
        i = 0;
        while (n_deliv < tgt && i < 60) begin
            @(posedge CLK);
            i++;
        end
        #1;
        chk(tag, 32'(n_deliv >= tgt), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int i;
        i = 0;
        do begin
            @(negedge CLK);
            i++;
        end while (!IMEM_REQ && i < 20);
        chk(tag, 32'(IMEM_REQ), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        n_deliv = 0; n_grant = 0; next_addr = '0;
        RST_N = 1'b0; INST_READY = 1'b1;
        gnt_en = 1'b1; resp_en = 1'b1;
        BR_TAKEN = 1'b0; BR_TARGET = '0;
        fill_exp(32'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req", 32'(IMEM_REQ), 32'd0);
        chk("rst_addr", IMEM_ADDR, 32'h0);
        chk("rst_inst", INST, 32'h0);
        chk("rst_pc", INST_PC, 32'h0);
        chk("rst_valid", 32'(INST_VALID), 32'd0);

        // cycle 0 = BOOT
        tick();
        RST_N = 1'b1;
        @(negedge CLK);
        chk("boot_req", 32'(IMEM_REQ), 32'd0);
        @(negedge CLK);
        chk("c1_req", 32'(IMEM_REQ), 32'd1);
        chk("c1_addr", IMEM_ADDR, 32'h0);
        @(negedge CLK);
        chk("c2_valid", 32'(INST_VALID), 32'd0);
        @(negedge CLK);
        chk("c3_valid", 32'(INST_VALID), 32'd1);
        chk("c3_pc", INST_PC, 32'h0);
        wait_deliv("stream", 3);

        // decoder stall
        INST_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (k >= 2) begin
                chk("stall_req", 32'(IMEM_REQ), 32'd0);
                chk("stall_valid", 32'(INST_VALID), 32'd1);
                chk("stall_pc", INST_PC, exp_q[0]);
                chk("stall_inst", INST, exp_q[0]);
                chk("stall_credit", 32'((n_grant - n_deliv) <= 2), 32'd1);
            end
        end
        tick();
        INST_READY = 1'b1;
        wait_deliv("release", 3);

        // grant withheld for 3 cycles
        gnt_en = 1'b0;
        wait_req("gnt_req");
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge CLK);
            chk("gnt_hold_req", 32'(IMEM_REQ), 32'd1);
            chk("gnt_hold_addr", IMEM_ADDR, next_addr);
        end
        tick();
        gnt_en = 1'b1;
        wait_deliv("gnt_resume", 3);

        // redirect with two outstanding
        resp_en = 1'b0;
        repeat (6) tick();
        @(negedge CLK);
        chk("two_outst", 32'(mq.size()), 32'd2);
        chk("two_outst_req", 32'(IMEM_REQ), 32'd0);
        tick();
        BR_TAKEN = 1'b1; BR_TARGET = 32'h0000_0103;
        tick();
        BR_TAKEN = 1'b0;
        fill_exp(32'h100);
        resp_en = 1'b1;
        @(negedge CLK);
        chk("br_valid", 32'(INST_VALID), 32'd0);
        chk("br_drain_req", 32'(IMEM_REQ), 32'd0);
        wait_req("br_req");
        chk("br_addr", IMEM_ADDR, 32'h100);
        wait_deliv("br_stream", 2);

        // redirect coinciding with grant and response
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (IMEM_REQ && IMEM_GNT && IMEM_RVALID) begin
                BR_TAKEN = 1'b1; BR_TARGET = 32'h0000_0200;
                found = 1'b1;
            end
        end
        chk("same_found", 32'(found), 32'd1);
        tick();
        BR_TAKEN = 1'b0;
        fill_exp(32'h200);
        @(negedge CLK);
        chk("same_valid", 32'(INST_VALID), 32'd0);
        chk("same_drain_req", 32'(IMEM_REQ), 32'd0);
        wait_req("same_req");
        chk("same_addr", IMEM_ADDR, 32'h200);
        wait_deliv("same_stream", 2);

        // address wrap
        BR_TAKEN = 1'b1; BR_TARGET = 32'hFFFF_FFF8;
        tick();
        BR_TAKEN = 1'b0;
        fill_exp(32'hFFFF_FFF8);
        g_log.delete();
        wait_deliv("wrap_stream", 4);
        chk("wrap_cnt", 32'(g_log.size() >= 3), 32'd1);
        chk("wrap_a0", g_log[0], 32'hFFFF_FFF8);
        chk("wrap_a1", g_log[1], 32'hFFFF_FFFC);
        chk("wrap_a2", g_log[2], 32'h0000_0000);

        // reset in the middle of a drain
        resp_en = 1'b0;
        repeat (6) tick();
        BR_TAKEN = 1'b1; BR_TARGET = 32'h300;
        tick();
        BR_TAKEN = 1'b0;
        tick();
        RST_N = 1'b0;
        #1;
        chk("mrst_req", 32'(IMEM_REQ), 32'd0);
        chk("mrst_addr", IMEM_ADDR, 32'h0);
        chk("mrst_valid", 32'(INST_VALID), 32'd0);
        chk("mrst_inst", INST, 32'h0);
        chk("mrst_pc", INST_PC, 32'h0);
        fill_exp(32'h0);
        resp_en = 1'b1;
        tick();
        tick();
        RST_N = 1'b1;
        wait_req("mrst_req2");
        chk("mrst_addr2", IMEM_ADDR, 32'h0);
        wait_deliv("mrst_stream", 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
